alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares the single combinational ALU (16-bit A/B operands, 3-bit FS function select, 16-bit out, zero_flag) between two requesters, e.g. the instruction-execute path and the address/branch path. It accepts one operation at a time over a valid/ready handshake, drives registered operands and function select into the ALU, and captures the result and zero flag. It then returns them to the granted requester as a one-cycle response pulse.

## Interface
- WIDTH, 16, operand/result width
- FSW, 3, function-select width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- r0_valid  in  1  requester 0 has an operation pending
- r0_ready  out  1  arbiter accepts requester 0 this cycle
- r0_fs  in  FSW  requester 0 function select
- r0_a, r0_b  in  WIDTH  requester 0 operands
- r1_valid, r1_ready, r1_fs, r1_a, r1_b: as above, requester 1
- alu_fs  out  FSW  registered FS to ALU
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_fs/alu_a/alu_b)
- alu_zero  in  1  ALU zero_flag
- r0_resp_valid, r1_resp_valid  out  1  one-cycle pulse: resp_data/resp_zero belong to that requester
- resp_data  out  WIDTH  captured ALU result
- resp_zero  out  1  captured zero flag
- busy  out  1  high in EXEC and RESP

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant is combinational:
  - only r0_valid -> requester 0; only r1_valid -> requester 1.
  - both valid -> the requester not equal to last_grant.
- IDLE ready: rN_ready = (state==IDLE) && grant==N && rN_valid.
- Handshake rule: an operation is accepted on the edge where rN_valid && rN_ready.
- On accept:
  - alu_fs/alu_a/alu_b <= granted requester's fs/a/b.
  - owner <= N; last_grant <= N.
  - state -> EXEC.
- EXEC: ALU settles on the registered inputs. At the edge: resp_data <= alu_out, resp_zero <= alu_zero; state -> RESP.
- RESP:
  - r{owner}_resp_valid = 1 for exactly this cycle; the other resp_valid stays 0.
  - No backpressure on responses; state -> IDLE.
- Output hold behaviour:
  - alu_fs/alu_a/alu_b hold their values outside accept edges; no glitching of ALU inputs during EXEC.
  - resp_data/resp_zero hold until the next EXEC capture.
- Requester inputs are sampled only on the accept edge. Later changes do not affect the in-flight operation.
- Ready is never asserted in EXEC or RESP, even if valid.

## Timing
- Reset values (rst high at an edge):
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins the first tie).
  - alu_fs=0, alu_a=0, alu_b=0, resp_data=0, resp_zero=0.
  - r0_resp_valid=r1_resp_valid=0, busy=0.
- Reset mid-operation (in EXEC or RESP) aborts the operation; no response pulse is issued.
- Latency: accept edge at cycle T -> EXEC in T+1 -> resp_valid high during T+2.
- Throughput: a new accept is possible in cycle T+3 (IDLE), so at most one operation per 3 cycles.
- Simultaneous valid in IDLE: exactly one ready is asserted, per round-robin. With continuous requests from both, grants alternate 0,1,0,1...
- A valid held through EXEC/RESP is accepted in the next IDLE cycle, subject to round-robin.
- Valid deasserted before being granted: no accept, no state change.
- busy=1 in exactly the EXEC and RESP cycles.

## Test plan
The bench uses a behavioural ALU stub: FS=000 -> A+B, FS=001 -> A-B, FS=010 -> A&B; zero = (out==0).

- Reset then idle: all outputs 0, r0_ready=r1_ready=0 with no valid, state stays IDLE.
- r0 alone, FS=000, A=B=16'h29CB:
  - r0_ready=1 in the accept cycle.
  - Two cycles later r0_resp_valid=1, resp_data=16'h5396, resp_zero=0, r1_resp_valid=0.
- r1 alone, FS=001, A=B=16'h29CB -> r1_resp_valid at T+2 with resp_data=16'h0000, resp_zero=1.
- Both valid continuously, r0 FS=010 A=16'hFF00 B=16'h0FF0, r1 FS=000 A=1 B=2:
  - First grant to r0 (resp 16'h0F00), second to r1 (resp 16'h0003), third to r0.
  - Accepts are spaced exactly 3 cycles apart.
- Operand change after accept: r0 changes A to 16'hFFFF during EXEC -> response still reflects the originally accepted operands; alu_a unchanged through EXEC/RESP.
- rst asserted during EXEC:
  - Next cycle is IDLE with all outputs at reset values and no resp_valid pulse.
  - A subsequent r0 request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Accepts one operation at a time and returns the result as a one-cycle response pulse.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FSW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [FSW-1:0]   r0_fs,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [FSW-1:0]   r1_fs,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [FSW-1:0]   alu_fs,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             r0_resp_valid,
  output logic             r1_resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q;
  logic   last_grant_q;
  logic   grant_c;
  logic   accept_c;

  // Grant selection, handshake and next-state logic
  always_comb begin
    state_d  = state_q;
    grant_c  = 1'b0;
    accept_c = 1'b0;
    r0_ready = 1'b0;
    r1_ready = 1'b0;

    // On a tie the requester that did not win last time is served
    if (r0_valid && r1_valid) begin
      grant_c = ~last_grant_q;
    end else if (r1_valid) begin
      grant_c = 1'b1;
    end else begin
      grant_c = 1'b0;
    end

    case (state_q)
      IDLE: begin
        r0_ready = r0_valid && (grant_c == 1'b0);
        r1_ready = r1_valid && (grant_c == 1'b1);
        accept_c = r0_ready || r1_ready;
        if (accept_c) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, ALU operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_fs       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      resp_data    <= '0;
      resp_zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        owner_q      <= grant_c;
        last_grant_q <= grant_c;
        if (grant_c) begin
          alu_fs <= r1_fs;
          alu_a  <= r1_a;
          alu_b  <= r1_b;
        end else begin
          alu_fs <= r0_fs;
          alu_a  <= r0_a;
          alu_b  <= r0_b;
        end
      end
      if (state_q == EXEC) begin
        resp_data <= alu_out;
        resp_zero <= alu_zero;
      end
    end
  end

  // Status outputs decoded directly from registered state
  assign busy          = (state_q == EXEC) || (state_q == RESP);
  assign r0_resp_valid = (state_q == RESP) && (owner_q == 1'b0);
  assign r1_resp_valid = (state_q == RESP) && (owner_q == 1'b1);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stub.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FSW   = 3;

  logic             clk;
  logic             rst;
  logic             r0_valid, r1_valid;
  logic             r0_ready, r1_ready;
  logic [FSW-1:0]   r0_fs, r1_fs;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [FSW-1:0]   alu_fs;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_zero;
  logic             r0_resp_valid, r1_resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .FSW(FSW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_fs(r0_fs), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_fs(r1_fs), .r1_a(r1_a), .r1_b(r1_b),
    .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .r0_resp_valid(r0_resp_valid), .r1_resp_valid(r1_resp_valid),
    .resp_data(resp_data), .resp_zero(resp_zero), .busy(busy)
  );

  // Behavioural ALU stub
  always_comb begin
    case (alu_fs)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v0, input logic v1,
                            input logic [15:0] data, input logic zero);
    check({tag, "_v0"}, 32'(r0_resp_valid), 32'(v0));
    check({tag, "_v1"}, 32'(r1_resp_valid), 32'(v1));
    check({tag, "_data"}, 32'(resp_data), 32'(data));
    check({tag, "_zero"}, 32'(resp_zero), 32'(zero));
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_fs = '0; r0_a = '0; r0_b = '0;
    r1_fs = '0; r1_a = '0; r1_b = '0;

    // Reset then idle
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_fs", 32'(alu_fs), 32'd0);
    check_resp("rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_r0_ready", 32'(r0_ready), 32'd0);
    check("idle_r1_ready", 32'(r1_ready), 32'd0);

    // r0 alone, add
    r0_valid = 1'b1; r0_fs = 3'b000; r0_a = 16'h29CB; r0_b = 16'h29CB;
    #1;
    check("r0_ready", 32'(r0_ready), 32'd1);
    check("r0_r1_ready", 32'(r1_ready), 32'd0);
    step();
    r0_valid = 1'b0;
    check("r0_exec_busy", 32'(busy), 32'd1);
    check("r0_exec_alu_a", 32'(alu_a), 32'h29CB);
    step();
    check_resp("r0_resp", 1'b1, 1'b0, 16'h5396, 1'b0);
    check("r0_resp_busy", 32'(busy), 32'd1);
    step();
    check("r0_after_busy", 32'(busy), 32'd0);
    check_resp("r0_after", 1'b0, 1'b0, 16'h5396, 1'b0);

    // r1 alone, subtract to zero
    r1_valid = 1'b1; r1_fs = 3'b001; r1_a = 16'h29CB; r1_b = 16'h29CB;
    #1;
    check("r1_ready", 32'(r1_ready), 32'd1);
    check("r1_r0_ready", 32'(r0_ready), 32'd0);
    step();
    r1_valid = 1'b0;
    step();
    check_resp("r1_resp", 1'b0, 1'b1, 16'h0000, 1'b1);
    step();

    // Both valid continuously: grants alternate 0,1,0 spaced 3 cycles apart
    r0_valid = 1'b1; r0_fs = 3'b010; r0_a = 16'hFF00; r0_b = 16'h0FF0;
    r1_valid = 1'b1; r1_fs = 3'b000; r1_a = 16'h0001; r1_b = 16'h0002;
    #1;
    check("rr1_r0_ready", 32'(r0_ready), 32'd1);
    check("rr1_r1_ready", 32'(r1_ready), 32'd0);
    step();
    check("rr1_exec_r0_ready", 32'(r0_ready), 32'd0);
    check("rr1_exec_r1_ready", 32'(r1_ready), 32'd0);
    step();
    check_resp("rr1_resp", 1'b1, 1'b0, 16'h0F00, 1'b0);
    check("rr1_resp_r1_ready", 32'(r1_ready), 32'd0);
    step();
    check("rr2_r1_ready", 32'(r1_ready), 32'd1);
    check("rr2_r0_ready", 32'(r0_ready), 32'd0);
    step();
    step();
    check_resp("rr2_resp", 1'b0, 1'b1, 16'h0003, 1'b0);
    step();
    check("rr3_r0_ready", 32'(r0_ready), 32'd1);
    check("rr3_r1_ready", 32'(r1_ready), 32'd0);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    check_resp("rr3_resp", 1'b1, 1'b0, 16'h0F00, 1'b0);
    step();

    // Operand change after accept does not affect in-flight operation
    r0_valid = 1'b1; r0_fs = 3'b000; r0_a = 16'h1234; r0_b = 16'h0101;
    step();
    r0_valid = 1'b0; r0_a = 16'hFFFF;
    #1;
    check("hold_exec_alu_a", 32'(alu_a), 32'h1234);
    step();
    check("hold_resp_alu_a", 32'(alu_a), 32'h1234);
    check_resp("hold_resp", 1'b1, 1'b0, 16'h1335, 1'b0);
    step();

    // Reset during EXEC aborts without a response
    r1_valid = 1'b1; r1_fs = 3'b000; r1_a = 16'h0005; r1_b = 16'h0006;
    step();
    r1_valid = 1'b0;
    check("abort_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check_resp("abort", 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    check("abort_idle_busy", 32'(busy), 32'd0);
    check_resp("abort_idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Subsequent r0 request completes normally
    r0_valid = 1'b1; r0_fs = 3'b001; r0_a = 16'h0010; r0_b = 16'h0003;
    #1;
    check("post_r0_ready", 32'(r0_ready), 32'd1);
    step();
    r0_valid = 1'b0;
    step();
    check_resp("post_resp", 1'b1, 1'b0, 16'h000D, 1'b0);
    step();
    check("post_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
